letter_collector: RTL and testbench
===================================

Name: letter_collector

Overview:
- Consumer side of the maze-init interface: captures the letter-placement bitmap and life budget broadcast by the game controller during initialisation.
- During play, takes the player's cell on each step, picks up the letter there, and checks it against the hidden-word letter set.
- Drives the `win`/`lose` inputs of the game controller and provides the live letter map to the renderer.

Parameters:
- size_y, 20, maze rows
- size_x, 40, maze columns
- NUM_LETTERS, 26, letters a..z; width of letter masks

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- init  in  1  one-cycle load strobe from game controller
- ilc  in  8  initial life count; sampled when init=1
- init_maze_letters  in  [0:size_x-1] x [size_y-1:0]  letter bitmap; sampled when init=1
- target_mask  in  NUM_LETTERS  bit i set = letter i is in the hidden word; sampled when init=1
- ready  in  1  game controller in play state
- step  in  1  one-cycle pulse: player entered cell (py,px)
- px  in  $clog2(size_x)  player column
- py  in  $clog2(size_y)  player row
- letter_map  out  [0:size_x-1] x [size_y-1:0]  letters still on the board
- found_mask  out  NUM_LETTERS  word letters collected so far
- lives  out  8  remaining lives
- busy  out  1  step is being evaluated; new steps ignored
- hit  out  1  one-cycle pulse: collected letter is in the word
- miss  out  1  one-cycle pulse: collected letter is not in the word
- win  out  1  level: every target letter found
- lose  out  1  level: lives exhausted

Behaviour:
- Reset (sync, Clk edge with Reset=1): state IDLE; letter_map, found_mask, lives, stored target all 0; busy/hit/miss/win/lose 0. Reset overrides every other input, including in mid-step.
- States: IDLE, LOAD, PLAY, CHECK, WON, LOST.
- init=1 in any state: next edge captures bitmap into letter_map, ilc into lives, target_mask internally; clears found_mask; enters LOAD. Any pending CHECK is discarded.
- LOAD, one cycle:
  - stored target == 0 -> WON
  - else lives == 0 -> LOST
  - else PLAY
  - Both zero: WON has priority.
- PLAY:
  - step=1 and ready=1: register px/py, go to CHECK. busy=1 from the following cycle.
  - step with ready=0: ignored.
- CHECK, one cycle, busy=1; steps arriving here are dropped.
  - Out-of-range coordinate (px>=size_x or py>=size_y) or map bit clear: no effect, back to PLAY.
  - Map bit set: clear it. Decode (py,px) through the letter position table to index k.
  - No table match: bit cleared only, no hit/miss, no life change.
  - k in target and not yet in found_mask: set found_mask[k], pulse hit.
  - k in target and already found: cannot occur (bit already cleared); treat as no-op.
  - k not in target: pulse miss; lives decrements, saturating at 0.
  - Next state: WON if updated found_mask == target; else LOST if lives became 0; else PLAY.
- hit/miss are registered and asserted the cycle after CHECK, same edge as the state change.
- Step-to-result latency: step at edge N -> CHECK at N+1 -> hit/miss/win/lose visible after edge N+2.
- WON/LOST: terminal. win (resp. lose) held at 1; steps ignored; busy=0. Exit only via init or Reset.
- win and lose are never both 1.

Decomposition:
- Package maze_pkg holds:
  - NUM_LETTERS
  - letter index enum (LTR_A..LTR_Z)
  - letter position table LETTER_Y/LETTER_X (a=(2,7), b=(7,1), ..., z=(16,15))
  - the collector state enum
  - The game controller's placement uses the same package table, so the two ends cannot diverge.
- Sub-module letter_decode: combinational. Inputs (py,px); outputs index[4:0] and valid, via 26 parallel comparisons against the table.

Test Plan:
- Reset=1 mid-CHECK -> next cycle state IDLE, lives=0, letter_map all 0, win=lose=0, busy=0.
- init with standard bitmap, ilc=0x63, target_mask = a|e|t -> after LOAD: lives=99, PLAY, letter_map bit (2,7)=1.
- Steps to (2,7), (4,9), (7,9) -> three hit pulses; found_mask = a|e|t; win=1 two cycles after third step; letter_map bits cleared.
- ilc=2, target = a only; steps to (7,1) b then (3,22) c -> two miss pulses, lives 2->1->0, lose=1; then step to (2,7) -> no change.
- Step to empty cell (0,0), step to out-of-range (py=25), second step during busy -> no pulses, lives unchanged, dropped step has no effect.
- init with target_mask=0 -> win=1 after LOAD. init with ilc=0 and nonzero target -> lose=1. Then init during WON -> clean reload into PLAY.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze letter definitions for the letter collector and game controller
// Purpose: letter count, letter index enum, letter position table (row/column per
//          letter) and the collector state enum. The game controller places letters
//          from the same table, so placement and decoding always agree.
// Ports:   none (package)
package maze_pkg;

  localparam int NUM_LETTERS = 26;

  typedef enum logic [4:0] {
    LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H, LTR_I,
    LTR_J, LTR_K, LTR_L, LTR_M, LTR_N, LTR_O, LTR_P, LTR_Q, LTR_R,
    LTR_S, LTR_T, LTR_U, LTR_V, LTR_W, LTR_X, LTR_Y, LTR_Z
  } letter_e;

  // Row (y) and column (x) of each letter, indexed by letter_e. All positions unique.
  localparam int unsigned LETTER_Y [NUM_LETTERS] = '{
     2,  7,  3,  5,  4,  9, 11, 13,  1, 15, 17,  6, 10,
    12, 14, 18, 19,  8, 16,  7,  3,  9, 11, 13, 18, 16
  };
  localparam int unsigned LETTER_X [NUM_LETTERS] = '{
     7,  1, 22, 30,  9, 14,  3, 25, 35,  8, 20, 17, 38,
    11, 33,  5, 27, 24,  2,  9, 12, 31, 19, 36, 13, 15
  };

  typedef enum logic [2:0] {
    IDLE, LOAD, PLAY, CHECK, WON, LOST
  } state_e;

endpackage

// File: rtl/letter_decode.sv
// rtl/letter_decode.sv - maps a maze cell to the letter placed there
// Purpose: combinational lookup of (py,px) against the letter position table using
//          one parallel comparator per letter.
// Ports:   py, px  - cell row / column
//          index   - letter index of the matching table entry (0 when no match)
//          valid   - 1 when the cell holds a table position
module letter_decode
  import maze_pkg::*;
#(
  parameter int size_y = 20,
  parameter int size_x = 40
) (
  input  logic [$clog2(size_y)-1:0] py,
  input  logic [$clog2(size_x)-1:0] px,
  output logic [4:0]                index,
  output logic                      valid
);

  logic [NUM_LETTERS-1:0] match;

  for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_cmp
    assign match[i] = (32'(py) == LETTER_Y[i]) && (32'(px) == LETTER_X[i]);
  end

  // Positions are unique, so at most one match bit is set; the loop just encodes it.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = NUM_LETTERS - 1; i >= 0; i--) begin
      if (match[i]) begin
        index = 5'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/letter_collector.sv
// rtl/letter_collector.sv - collects maze letters against the hidden word and tracks lives
// Purpose: loads the letter bitmap, life budget and target letter set on init, then
//          evaluates each player step: picks up the letter at the cell, flags hit/miss,
//          spends lives on misses and reports win/lose to the game controller.
// Ports:   Clk, Reset        - clock, synchronous active-high reset
//          init, ilc, init_maze_letters, target_mask - load strobe and load data
//          ready, step, px, py - play-state qualifier, step pulse, player cell
//          letter_map, found_mask, lives - live board / progress / life count
//          busy, hit, miss, win, lose    - step evaluation status and game result
module letter_collector
  import maze_pkg::*;
#(
  parameter int size_y = 20,
  parameter int size_x = 40
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             init,
  input  logic [7:0]                       ilc,
  input  logic [0:size_x-1][size_y-1:0]    init_maze_letters,
  input  logic [NUM_LETTERS-1:0]           target_mask,
  input  logic                             ready,
  input  logic                             step,
  input  logic [$clog2(size_x)-1:0]        px,
  input  logic [$clog2(size_y)-1:0]        py,
  output logic [0:size_x-1][size_y-1:0]    letter_map,
  output logic [NUM_LETTERS-1:0]           found_mask,
  output logic [7:0]                       lives,
  output logic                             busy,
  output logic                             hit,
  output logic                             miss,
  output logic                             win,
  output logic                             lose
);

  localparam int YW = $clog2(size_y);
  localparam int XW = $clog2(size_x);

  state_e                          state_q, state_d;
  logic [0:size_x-1][size_y-1:0]   letter_map_q, letter_map_d;
  logic [NUM_LETTERS-1:0]          found_q, found_d;
  logic [NUM_LETTERS-1:0]          target_q, target_d;
  logic [7:0]                      lives_q, lives_d;
  logic [XW-1:0]                   px_q, px_d;
  logic [YW-1:0]                   py_q, py_d;
  logic                            busy_q, busy_d;
  logic                            hit_q, hit_d;
  logic                            miss_q, miss_d;
  logic                            win_q, win_d;
  logic                            lose_q, lose_d;

  logic [4:0] dec_index;
  logic       dec_valid;
  logic       in_range;
  logic       map_bit;

  letter_decode #(
    .size_y (size_y),
    .size_x (size_x)
  ) u_decode (
    .py    (py_q),
    .px    (px_q),
    .index (dec_index),
    .valid (dec_valid)
  );

  // The registered coordinate may exceed the board; never index the map with it then.
  assign in_range = (32'(px_q) < 32'(size_x)) && (32'(py_q) < 32'(size_y));
  assign map_bit  = in_range ? letter_map_q[px_q][py_q] : 1'b0;

  always_comb begin
    state_d      = state_q;
    letter_map_d = letter_map_q;
    found_d      = found_q;
    target_d     = target_q;
    lives_d      = lives_q;
    px_d         = px_q;
    py_d         = py_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;

    if (init) begin
      // Load wins over everything, including an in-flight CHECK.
      letter_map_d = init_maze_letters;
      lives_d      = ilc;
      target_d     = target_mask;
      found_d      = '0;
      state_d      = LOAD;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LOAD: begin
          if (target_q == '0)      state_d = WON;
          else if (lives_q == 8'd0) state_d = LOST;
          else                      state_d = PLAY;
        end
        PLAY: begin
          if (step && ready) begin
            px_d    = px;
            py_d    = py;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (map_bit) begin
            letter_map_d[px_q][py_q] = 1'b0;
            if (dec_valid) begin
              if (target_q[dec_index]) begin
                if (!found_q[dec_index]) begin
                  found_d[dec_index] = 1'b1;
                  hit_d              = 1'b1;
                end
              end else begin
                miss_d  = 1'b1;
                lives_d = (lives_q == 8'd0) ? 8'd0 : lives_q - 8'd1;
              end
            end
          end
          if (found_d == target_q)  state_d = WON;
          else if (lives_d == 8'd0) state_d = LOST;
          else                      state_d = PLAY;
        end
        WON:  state_d = WON;
        LOST: state_d = LOST;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == CHECK);
    win_d  = (state_d == WON);
    lose_d = (state_d == LOST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      letter_map_q <= '0;
      found_q      <= '0;
      target_q     <= '0;
      lives_q      <= 8'd0;
      px_q         <= '0;
      py_q         <= '0;
      busy_q       <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      letter_map_q <= letter_map_d;
      found_q      <= found_d;
      target_q     <= target_d;
      lives_q      <= lives_d;
      px_q         <= px_d;
      py_q         <= py_d;
      busy_q       <= busy_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign letter_map = letter_map_q;
  assign found_mask = found_q;
  assign lives      = lives_q;
  assign busy       = busy_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_letter_collector.sv
// tb/tb_letter_collector.sv - directed self-checking bench for letter_collector
module tb_letter_collector;
  import maze_pkg::*;

  localparam int SY = 20;
  localparam int SX = 40;

  localparam logic [25:0] M_A = 26'h1;
  localparam logic [25:0] M_B = 26'h2;
  localparam logic [25:0] M_E = 26'h10;
  localparam logic [25:0] M_T = 26'h80000;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     init;
  logic [7:0]               ilc;
  logic [0:SX-1][SY-1:0]    init_maze_letters;
  logic [25:0]              target_mask;
  logic                     ready;
  logic                     step;
  logic [5:0]               px;
  logic [4:0]               py;
  logic [0:SX-1][SY-1:0]    letter_map;
  logic [25:0]              found_mask;
  logic [7:0]               lives;
  logic                     busy, hit, miss, win, lose;

  logic [0:SX-1][SY-1:0]    std_map;
  int n_tests = 0;
  int n_fail  = 0;

  letter_collector #(.size_y(SY), .size_x(SX)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .init              (init),
    .ilc               (ilc),
    .init_maze_letters (init_maze_letters),
    .target_mask       (target_mask),
    .ready             (ready),
    .step              (step),
    .px                (px),
    .py                (py),
    .letter_map        (letter_map),
    .found_mask        (found_mask),
    .lives             (lives),
    .busy              (busy),
    .hit               (hit),
    .miss              (miss),
    .win               (win),
    .lose              (lose)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // init pulse, then the LOAD cycle: returns with the post-LOAD state visible.
  task automatic do_init(input logic [7:0] l, input logic [25:0] t);
    init = 1'b1; ilc = l; target_mask = t; init_maze_letters = std_map;
    tick();
    init = 1'b0;
    tick();
  endtask

  // Step pulse, then the CHECK cycle: returns with the result visible.
  task automatic do_step(input logic [4:0] y, input logic [5:0] x);
    step = 1'b1; py = y; px = x;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    std_map = '0;
    for (int i = 0; i < NUM_LETTERS; i++) std_map[LETTER_X[i]][LETTER_Y[i]] = 1'b1;
    Reset = 1'b1; init = 1'b0; ilc = 8'd0; init_maze_letters = '0; target_mask = '0;
    ready = 1'b1; step = 1'b0; px = '0; py = '0;
    tick(); tick();
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_map", 32'(letter_map != '0), 32'd0);
    check("rst_flags", {27'd0, busy, hit, miss, win, lose}, 32'd0);
    Reset = 1'b0;
    tick();

    // Three hits win the a|e|t word.
    do_init(8'h63, M_A | M_E | M_T);
    check("load_lives", 32'(lives), 32'd99);
    check("load_map_a", 32'(letter_map[7][2]), 32'd1);
    check("load_flags", {27'd0, busy, hit, miss, win, lose}, 32'd0);
    step = 1'b1; py = 5'd2; px = 6'd7;
    tick();
    step = 1'b0;
    check("busy_in_check", 32'(busy), 32'd1);
    tick();
    check("hit_a", {30'd0, hit, miss}, 32'b10);
    check("found_a", 32'(found_mask), 32'(M_A));
    check("map_a_clear", 32'(letter_map[7][2]), 32'd0);
    tick();
    check("hit_pulse_end", 32'(hit), 32'd0);
    do_step(5'd4, 6'd9);
    check("hit_e", {30'd0, hit, miss}, 32'b10);
    check("win_not_yet", 32'(win), 32'd0);
    do_step(5'd7, 6'd9);
    check("hit_t", {30'd0, hit, miss}, 32'b10);
    check("found_aet", 32'(found_mask), 32'(M_A | M_E | M_T));
    check("win_aet", {30'd0, win, lose}, 32'b10);
    check("lives_kept", 32'(lives), 32'd99);
    check("map_e_t_clear", {30'd0, letter_map[9][4], letter_map[9][7]}, 32'd0);

    // Reset in the middle of a CHECK.
    do_init(8'd99, M_A);
    step = 1'b1; py = 5'd2; px = 6'd7;
    tick();
    step = 1'b0;
    check("mid_check_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    tick();
    check("midrst_lives", 32'(lives), 32'd0);
    check("midrst_map", 32'(letter_map != '0), 32'd0);
    check("midrst_flags", {27'd0, busy, hit, miss, win, lose}, 32'd0);
    Reset = 1'b0;
    tick();

    // Misses exhaust two lives.
    do_init(8'd2, M_A);
    do_step(5'd7, 6'd1);
    check("miss_b", {30'd0, hit, miss}, 32'b01);
    check("lives_1", 32'(lives), 32'd1);
    check("lose_not_yet", 32'(lose), 32'd0);
    do_step(5'd3, 6'd22);
    check("miss_c", {30'd0, hit, miss}, 32'b01);
    check("lives_0", 32'(lives), 32'd0);
    check("lose_set", {30'd0, win, lose}, 32'b01);
    do_step(5'd2, 6'd7);
    check("lost_ignores", {28'd0, busy, hit, miss, lose}, 32'b0001);
    check("lost_found", 32'(found_mask), 32'd0);
    check("lost_map_a", 32'(letter_map[7][2]), 32'd1);

    // Empty cell, out-of-range cell, and a step dropped while busy.
    do_init(8'd5, M_A | M_B);
    do_step(5'd0, 6'd0);
    check("empty_cell", {29'd0, hit, miss, busy}, 32'd0);
    do_step(5'd25, 6'd7);
    check("oob_cell", {29'd0, hit, miss, busy}, 32'd0);
    check("oob_lives", 32'(lives), 32'd5);
    step = 1'b1; py = 5'd7; px = 6'd1;
    tick();
    py = 5'd3; px = 6'd22;
    tick();
    step = 1'b0;
    check("hit_b_busy_case", {30'd0, hit, miss}, 32'b10);
    tick();
    check("drop_no_miss", {29'd0, hit, miss, busy}, 32'd0);
    check("drop_lives", 32'(lives), 32'd5);
    check("drop_map_c", 32'(letter_map[22][3]), 32'd1);

    // LOAD boundary cases and reload out of WON.
    do_init(8'd5, 26'd0);
    check("empty_target_win", {30'd0, win, lose}, 32'b10);
    do_init(8'd0, M_A);
    check("zero_lives_lose", {30'd0, win, lose}, 32'b01);
    do_init(8'd0, 26'd0);
    check("both_zero_win", {30'd0, win, lose}, 32'b10);
    do_init(8'd3, M_A);
    check("reload_flags", {27'd0, busy, hit, miss, win, lose}, 32'd0);
    check("reload_lives", 32'(lives), 32'd3);
    do_step(5'd2, 6'd7);
    check("reload_hit_win", {29'd0, hit, win, lose}, 32'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
